// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control logic.
// Forwarding selects are encoded as the ALU operand mux expects them.
package mips_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one ALU operand.
// The youngest producer (MEM) wins over WB, and r0 is never forwarded.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_dest_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_dest_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (mem_reg_write_i && (mem_dest_i != 5'd0) && (mem_dest_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_reg_write_i && (wb_dest_i != 5'd0) && (wb_dest_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freeze on data-memory wait, flush on taken
// branch, one-cycle bubble on load-use, plus forwarding selects and counters.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rs_fw,
  input  logic [4:0]       ex_rt_fw,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic [4:0]       mem_dest,
  input  logic [4:0]       wb_dest,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if2id_write,
  output logic             id2exe_write,
  output logic             exe2mem_write,
  output logic             if2id_flush,
  output logic             id2exe_flush,
  output logic             exe2mem_flush,
  output logic             mem2wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              timeout_q, timeout_d;

  logic       freeze, flush, load_use;
  logic [1:0] sel_a, sel_b;

  // In MEM_WAIT the access is already in flight, so only ready matters.
  assign freeze   = (state_q == RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;
  assign flush    = branch_taken && !freeze;
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt)) && !flush && !freeze;

  always_comb begin
    pc_write      = 1'b1;
    if2id_write   = 1'b1;
    id2exe_write  = 1'b1;
    exe2mem_write = 1'b1;
    if2id_flush   = 1'b0;
    id2exe_flush  = 1'b0;
    exe2mem_flush = 1'b0;
    mem2wb_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if2id_write   = 1'b0;
      id2exe_write  = 1'b0;
      exe2mem_write = 1'b0;
      if2id_flush   = 1'b1;
      id2exe_flush  = 1'b1;
      exe2mem_flush = 1'b1;
      mem2wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if2id_write   = 1'b0;
      id2exe_write  = 1'b0;
      exe2mem_write = 1'b0;
      mem2wb_bubble = 1'b1;
    end else if (flush) begin
      if2id_flush   = 1'b1;
      id2exe_flush  = 1'b1;
      exe2mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if2id_write   = 1'b0;
      id2exe_flush  = 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .src_i           (ex_rs_fw),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_i      (mem_dest),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_i       (wb_dest),
    .sel_o           (sel_a)
  );

  fwd_unit u_fwd_b (
    .src_i           (ex_rt_fw),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_i      (mem_dest),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_i       (wb_dest),
    .sel_o           (sel_b)
  );

  assign fwd_a = rst ? FWD_REG : sel_a;
  assign fwd_b = rst ? FWD_REG : sel_b;

  // Wait counter restarts from zero on every MEM_WAIT entry and saturates at TIMEOUT.
  always_comb begin
    state_d   = freeze ? MEM_WAIT : RUN;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (state_q == MEM_WAIT) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      if (wait_d == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end
    stall_d = stall_q;
    if (!pc_write && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cnt   = stall_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a default instance and a small one
// (TIMEOUT=4, CNT_W=2) share stimulus and are checked against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int BIG_TIMEOUT   = 64;
  localparam int BIG_CNT_W     = 16;
  localparam int SMALL_TIMEOUT = 4;
  localparam int SMALL_CNT_W   = 2;

  typedef struct packed {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       exMemRead;
    logic [4:0] exRt;
    logic [4:0] exRsFw;
    logic [4:0] exRtFw;
    logic       memRegWrite;
    logic       wbRegWrite;
    logic [4:0] memDest;
    logic [4:0] wbDest;
    logic       branchTaken;
    logic       dmemReq;
    logic       dmemReady;
  } stim_t;

  typedef struct packed {
    stim_t      in;
    logic [3:0] writes;
    logic [3:0] flushes;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt, ex_rs_fw, ex_rt_fw, mem_dest, wb_dest;
  logic ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ready;

  logic pc_write, if2id_write, id2exe_write, exe2mem_write;
  logic if2id_flush, id2exe_flush, exe2mem_flush, mem2wb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [BIG_CNT_W-1:0] stall_cnt;
  logic mem_timeout;

  logic smPcWrite, smIf2idWrite, smId2exeWrite, smExe2memWrite;
  logic smIf2idFlush, smId2exeFlush, smExe2memFlush, smMem2wbBubble;
  logic [1:0] smFwdA, smFwdB;
  logic [SMALL_CNT_W-1:0] smStallCnt;
  logic smMemTimeout;

  int checks = 0;
  int errors = 0;

  bit mWaiting;
  int mWaitCycles, mStallBig, mStallSmall;
  bit mToBig, mToSmall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(BIG_TIMEOUT), .CNT_W(BIG_CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_rs_fw(ex_rs_fw), .ex_rt_fw(ex_rt_fw), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if2id_write(if2id_write), .id2exe_write(id2exe_write),
    .exe2mem_write(exe2mem_write), .if2id_flush(if2id_flush), .id2exe_flush(id2exe_flush),
    .exe2mem_flush(exe2mem_flush), .mem2wb_bubble(mem2wb_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  pipe_hazard_ctrl #(.TIMEOUT(SMALL_TIMEOUT), .CNT_W(SMALL_CNT_W)) dutSmall (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_rs_fw(ex_rs_fw), .ex_rt_fw(ex_rt_fw), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(smPcWrite), .if2id_write(smIf2idWrite), .id2exe_write(smId2exeWrite),
    .exe2mem_write(smExe2memWrite), .if2id_flush(smIf2idFlush), .id2exe_flush(smId2exeFlush),
    .exe2mem_flush(smExe2memFlush), .mem2wb_bubble(smMem2wbBubble), .fwd_a(smFwdA),
    .fwd_b(smFwdB), .stall_cnt(smStallCnt), .mem_timeout(smMemTimeout)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [1:0] fwdModel(input logic [4:0] src, input stim_t s);
    if (s.memRegWrite && s.memDest != 0 && s.memDest == src) return 2'b10;
    if (s.wbRegWrite && s.wbDest != 0 && s.wbDest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mWaiting    = 0;
    mWaitCycles = 0;
    mStallBig   = 0;
    mStallSmall = 0;
    mToBig      = 0;
    mToSmall    = 0;
  endtask

  // Drives one cycle of inputs just after the falling edge and lets them settle.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    id_rs = s.idRs; id_rt = s.idRt; ex_mem_read = s.exMemRead; ex_rt = s.exRt;
    ex_rs_fw = s.exRsFw; ex_rt_fw = s.exRtFw; mem_reg_write = s.memRegWrite;
    wb_reg_write = s.wbRegWrite; mem_dest = s.memDest; wb_dest = s.wbDest;
    branch_taken = s.branchTaken; dmem_req = s.dmemReq; dmem_ready = s.dmemReady;
    #1;
  endtask

  // Compares both instances with the model for the current cycle, then steps the model.
  task automatic checkOutput(input stim_t s);
    bit frozen, taken, hazard;
    logic [3:0] expW, expF;
    frozen = !s.dmemReady && (mWaiting || s.dmemReq);
    taken  = s.branchTaken && !frozen;
    hazard = !frozen && !taken && s.exMemRead && s.exRt != 0 &&
             (s.exRt == s.idRs || s.exRt == s.idRt);
    expW = frozen ? 4'b0000 : (hazard ? 4'b0011 : 4'b1111);
    expF = frozen ? 4'b0001 : (taken ? 4'b1110 : (hazard ? 4'b0100 : 4'b0000));
    checkEq("writes", {pc_write, if2id_write, id2exe_write, exe2mem_write}, expW);
    checkEq("flushes", {if2id_flush, id2exe_flush, exe2mem_flush, mem2wb_bubble}, expF);
    checkEq("fwd_a", fwd_a, fwdModel(s.exRsFw, s));
    checkEq("fwd_b", fwd_b, fwdModel(s.exRtFw, s));
    checkEq("stall_cnt", stall_cnt, mStallBig);
    checkEq("mem_timeout", mem_timeout, mToBig);
    checkEq("small writes", {smPcWrite, smIf2idWrite, smId2exeWrite, smExe2memWrite}, expW);
    checkEq("small flushes", {smIf2idFlush, smId2exeFlush, smExe2memFlush, smMem2wbBubble}, expF);
    checkEq("small fwd", {smFwdA, smFwdB}, {fwdModel(s.exRsFw, s), fwdModel(s.exRtFw, s)});
    checkEq("small stall_cnt", smStallCnt, mStallSmall);
    checkEq("small mem_timeout", smMemTimeout, mToSmall);
    if (expW[3] == 1'b0) begin
      mStallBig   = (mStallBig   < (1 << BIG_CNT_W) - 1)   ? mStallBig + 1   : mStallBig;
      mStallSmall = (mStallSmall < (1 << SMALL_CNT_W) - 1) ? mStallSmall + 1 : mStallSmall;
    end
    if (mWaiting) begin
      mWaitCycles++;
      if (mWaitCycles >= BIG_TIMEOUT) mToBig = 1;
      if (mWaitCycles >= SMALL_TIMEOUT) mToSmall = 1;
    end
    if (frozen && !mWaiting) mWaitCycles = 0;
    mWaiting = frozen;
  endtask

  task automatic runCycle(input stim_t s);
    applyStimulus(s);
    checkOutput(s);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
  task automatic resetDut();
    stim_t s;
    s = idle();
    s.memRegWrite = 1; s.memDest = 5; s.exRsFw = 5; s.exRtFw = 5;
    applyStimulus(s);
    rst = 1'b1;
    #1;
    checkEq("reset writes", {pc_write, if2id_write, id2exe_write, exe2mem_write}, 4'b0000);
    checkEq("reset flushes", {if2id_flush, id2exe_flush, exe2mem_flush, mem2wb_bubble}, 4'b1111);
    checkEq("reset fwd", {fwd_a, fwd_b}, 4'b0000);
    checkEq("reset stall_cnt", stall_cnt, 0);
    checkEq("reset timeout", {mem_timeout, smMemTimeout}, 2'b00);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[12];
    stim_t s;
    rst = 1'b0;
    applyStimulus(idle());
    resetDut();

    s = idle();                                               vecs[0]  = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};
    s = idle(); s.exMemRead = 1; s.exRt = 2; s.idRs = 2;      vecs[1]  = '{s, 4'b0011, 4'b0100, 2'b00, 2'b00};
    s = idle(); s.exMemRead = 1; s.exRt = 2; s.idRt = 2; s.idRs = 9;
                                                              vecs[2]  = '{s, 4'b0011, 4'b0100, 2'b00, 2'b00};
    s = idle(); s.exMemRead = 1; s.exRt = 0; s.idRs = 0;      vecs[3]  = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};
    s = idle(); s.exMemRead = 1; s.exRt = 2; s.idRs = 3; s.idRt = 4;
                                                              vecs[4]  = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};
    s = idle(); s.exMemRead = 1; s.exRt = 2; s.idRs = 2; s.branchTaken = 1;
                                                              vecs[5]  = '{s, 4'b1111, 4'b1110, 2'b00, 2'b00};
    s = idle(); s.memRegWrite = 1; s.wbRegWrite = 1; s.memDest = 5; s.wbDest = 5; s.exRsFw = 5; s.exRtFw = 7;
                                                              vecs[6]  = '{s, 4'b1111, 4'b0000, 2'b10, 2'b00};
    s = idle(); s.wbRegWrite = 1; s.memDest = 5; s.wbDest = 5; s.exRsFw = 5; s.exRtFw = 5;
                                                              vecs[7]  = '{s, 4'b1111, 4'b0000, 2'b01, 2'b01};
    s = idle(); s.memRegWrite = 1; s.wbRegWrite = 1;          vecs[8]  = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};
    s = idle(); s.memRegWrite = 1; s.wbRegWrite = 1; s.memDest = 6; s.wbDest = 5; s.exRsFw = 5; s.exRtFw = 6;
                                                              vecs[9]  = '{s, 4'b1111, 4'b0000, 2'b01, 2'b10};
    s = idle(); s.exRt = 2; s.idRs = 2;                       vecs[10] = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};
    s = idle(); s.dmemReq = 1; s.dmemReady = 1;               vecs[11] = '{s, 4'b1111, 4'b0000, 2'b00, 2'b00};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkEq($sformatf("vec%0d writes", i), {pc_write, if2id_write, id2exe_write, exe2mem_write}, vecs[i].writes);
      checkEq($sformatf("vec%0d flushes", i), {if2id_flush, id2exe_flush, exe2mem_flush, mem2wb_bubble}, vecs[i].flushes);
      checkEq($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].fa);
      checkEq($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].fb);
      checkOutput(vecs[i].in);
    end
    runCycle(idle());
    checkEq("table stall_cnt", stall_cnt, 2);

    // Three-cycle memory wait with a branch arriving while frozen.
    resetDut();
    s = idle(); s.dmemReq = 1;
    runCycle(s);
    runCycle(s);
    s.branchTaken = 1;
    runCycle(s);
    checkEq("frozen branch ignored", {exe2mem_flush, pc_write, mem2wb_bubble}, 3'b001);
    s.dmemReady = 1;
    runCycle(s);
    checkEq("release flush", {if2id_flush, id2exe_flush, exe2mem_flush, pc_write}, 4'b1111);
    runCycle(idle());
    checkEq("freeze stall_cnt", stall_cnt, 3);

    // Memory never ready: small instance times out after four MEM_WAIT cycles.
    resetDut();
    s = idle(); s.dmemReq = 1;
    runCycle(s);
    s.dmemReq = 0;
    for (int k = 1; k <= 8; k++) begin
      runCycle(s);
      checkEq($sformatf("timeout wait%0d", k), smMemTimeout, (k >= 5) ? 1 : 0);
    end
    checkEq("big no timeout", mem_timeout, 0);
    resetDut();
    runCycle(idle());
    checkEq("after reset run", {pc_write, smMemTimeout}, 2'b10);

    // Repeated load-use stalls saturate the 2-bit counter.
    resetDut();
    s = idle(); s.exMemRead = 1; s.exRt = 4; s.idRt = 4;
    for (int k = 0; k < 5; k++) runCycle(s);
    runCycle(idle());
    checkEq("small stall saturate", smStallCnt, 3);
    checkEq("big stall count", stall_cnt, 5);

    // Random traffic against the model.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) resetDut();
      s.idRs        = 5'($urandom_range(0, 7));
      s.idRt        = 5'($urandom_range(0, 7));
      s.exMemRead   = ($urandom_range(0, 9) < 4);
      s.exRt        = 5'($urandom_range(0, 7));
      s.exRsFw      = 5'($urandom_range(0, 7));
      s.exRtFw      = 5'($urandom_range(0, 7));
      s.memRegWrite = 1'($urandom);
      s.wbRegWrite  = 1'($urandom);
      s.memDest     = 5'($urandom_range(0, 7));
      s.wbDest      = 5'($urandom_range(0, 7));
      s.branchTaken = ($urandom_range(0, 9) < 2);
      s.dmemReq     = ($urandom_range(0, 9) < 3);
      s.dmemReady   = ($urandom_range(0, 9) < 6);
      runCycle(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Drives the write enables and flush/bubble controls of PC, IF2ID, ID2EXE, EXE2MEM and MEM2WB. It resolves load-use hazards, taken-branch flushes and data-memory wait states, and generates EX-stage forwarding selects. Also keeps a stall-cycle counter and a memory-timeout flag.

## Interface
Parameters:
- TIMEOUT, 64: MEM_WAIT cycles before mem_timeout sets (≥1).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- id_rs, id_rt  in  5 each  source regs of instruction in ID (IF2ID inst[25:21], [20:16]).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination in EX (ID2EXE dest1).
- ex_rs_fw, ex_rt_fw  in  5 each  EX source regs for forwarding.
- mem_reg_write, wb_reg_write  in  1 each  RegWrite in MEM / WB.
- mem_dest, wb_dest  in  5 each  destination reg in MEM / WB.
- branch_taken  in  1  Branch AND Zero from EXE2MEM (branch resolved in MEM).
- dmem_req  in  1  MEM stage accesses data memory.
- dmem_ready  in  1  data memory completes this cycle.
- pc_write, if2id_write, id2exe_write, exe2mem_write  out  1 each  register enables.
- if2id_flush, id2exe_flush, exe2mem_flush, mem2wb_bubble  out  1 each  load NOP/zeroed control bits.
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 MEM, 01 WB.
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating.
- mem_timeout  out  1  sticky error.

## Operation
- States: RUN, MEM_WAIT. All controls combinational from state and inputs; state, wait counter, stall_cnt, mem_timeout registered.
- Priority per cycle: freeze > flush > load-use stall > normal.
- Freeze (RUN with dmem_req=1 and dmem_ready=0, or MEM_WAIT with dmem_ready=0): all four *_write=0 and mem2wb_bubble=1. Other flushes 0.
- RUN→MEM_WAIT on the freeze condition. MEM_WAIT→RUN on dmem_ready=1. That cycle is a normal advance and is subject to flush/load-use.
- Flush (branch_taken=1, not frozen): if2id_flush=id2exe_flush=exe2mem_flush=1 for one cycle; all writes 1 (PC takes target).
- Load-use (ex_mem_read=1, ex_rt≠0, ex_rt∈{id_rs,id_rt}, no flush, no freeze): pc_write=if2id_write=0, id2exe_flush=1, others advance. Lasts exactly one cycle because the bubble clears the condition.
- Branch and load-use in same cycle: flush only, no stall.
- Forwarding, per operand: MEM match (mem_reg_write, mem_dest≠0, equal) → 10; else WB match → 01; else 00. Register 0 never forwards.
- Wait counter: cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle. At TIMEOUT, mem_timeout←1 until rst. Waiting continues.
- stall_cnt +1 every cycle pc_write=0 (freeze or load-use). Saturates at 2^CNT_W−1.

## Timing
- Reset: state RUN, counters 0, mem_timeout 0. While rst=1, all *_write=0 and all flush/bubble=1; fwd_a/fwd_b=00.
- Zero-latency controls: a hazard seen in cycle n is acted on at edge n+1.
- dmem_ready with dmem_req in the same RUN cycle: no stall.
- rst mid-MEM_WAIT: asynchronous return to RUN; the pending access is abandoned.
- branch_taken during freeze: ignored until release. EXE2MEM holds it stable, so the flush occurs on the release cycle.

## Structure
- mips_pkg: state enum (RUN, MEM_WAIT), FWD_REG/FWD_MEM/FWD_WB constants.
- Sub-module fwd_unit: pure combinational forwarding select, instantiated twice (operands a, b).
- FSM, counters and priority logic stay in pipe_hazard_ctrl.

## Test plan
- Load r2 in EX, ID reads r2 → one cycle pc_write=0, id2exe_flush=1, stall_cnt 0→1. ex_rt=0 → no stall.
- branch_taken=1 with simultaneous load-use → three flushes=1, pc_write=1, stall_cnt unchanged.
- dmem_req=1, dmem_ready after 3 cycles → freeze 3 cycles, mem2wb_bubble=1, release on ready cycle, stall_cnt=3.
- TIMEOUT=4, ready never asserted → mem_timeout=1 after 4 MEM_WAIT cycles and stays set. rst clears it and returns to RUN.
- mem_dest=wb_dest=ex_rs_fw=5, both writing → fwd_a=10. Only WB writing → 01. Dest 0 → 00.
- CNT_W=2, 5 stall cycles → stall_cnt saturates at 3.
